// File: rtl/load_store_unit.sv
// Load/store front end for data_memory: sizes and extends loads, merges sub-word
// stores with a read-modify-write, and rejects misaligned or illegal requests.
module load_store_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        Mem_read,
  output logic        Mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] Read_data
);

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_WAIT,
    RMW_RD,
    RMW_WAIT,
    ST_WR,
    RESP
  } state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        mem_read_q;
  logic        mem_write_q;

  logic        req_illegal;
  logic        req_misaligned;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_result;
  logic [31:0] merged_word;

  always_comb begin
    req_illegal = 1'b1;
    if (req_load) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
        default:                                req_illegal = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
        default:                req_illegal = 1'b1;
      endcase
    end
  end

  // funct3[1:0] encodes the access size for every legal load and store
  assign req_misaligned = CHECK_ALIGN &&
                          (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));

  always_comb begin
    rd_byte = Read_data[7:0];
    case (lane_q)
      2'd0: rd_byte = Read_data[7:0];
      2'd1: rd_byte = Read_data[15:8];
      2'd2: rd_byte = Read_data[23:16];
      2'd3: rd_byte = Read_data[31:24];
      default: rd_byte = Read_data[7:0];
    endcase
    rd_half = lane_q[1] ? Read_data[31:16] : Read_data[15:0];

    case (funct3_q)
      3'b000:  load_result = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_result = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_result = {24'd0, rd_byte};
      3'b101:  load_result = {16'd0, rd_half};
      default: load_result = Read_data;
    endcase

    merged_word = Read_data;
    if (funct3_q[0]) begin
      if (lane_q[1]) merged_word[31:16] = wdata_q;
      else           merged_word[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0: merged_word[7:0]   = wdata_q[7:0];
        2'd1: merged_word[15:8]  = wdata_q[7:0];
        2'd2: merged_word[23:16] = wdata_q[7:0];
        2'd3: merged_word[31:24] = wdata_q[7:0];
        default: merged_word = Read_data;
      endcase
    end
  end

  // Strobes are gated by reset so an in-flight store can never reach memory
  assign Mem_read  = mem_read_q  & reset;
  assign Mem_write = mem_write_q & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q   <= req_funct3;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata[15:0];
            mem_addr   <= {req_addr[31:2], 2'b00};
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b0;
            if (req_illegal || req_misaligned) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_load) begin
              mem_read_q <= 1'b1;
              state      <= LD_RD;
            end else if (req_funct3[1:0] == 2'b10) begin
              mem_wdata   <= req_wdata;
              mem_write_q <= 1'b1;
              state       <= ST_WR;
            end else begin
              mem_read_q <= 1'b1;
              state      <= RMW_RD;
            end
          end
        end
        LD_RD: state <= LD_WAIT;
        LD_WAIT: begin
          resp_rdata <= load_result;
          mem_read_q <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: state <= RMW_WAIT;
        RMW_WAIT: begin
          mem_wdata   <= merged_word;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          state       <= ST_WR;
        end
        ST_WR: begin
          mem_write_q <= 1'b0;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          resp_valid  <= 1'b0;
          req_ready   <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits directly upstream of `data_memory` in the non-pipelined core and turns one load/store request from execute/control into word-wide accesses on the `Mem_read`/`Mem_write`/address/`write_data`/`Read_data` port set. Handles byte/halfword/word sizing, sign/zero extension of loads, read-modify-write for sub-word stores, and alignment checking. The core stalls on `req_ready` and consumes a single-cycle `resp_valid` pulse.

## Interface
- `CHECK_ALIGN`, default 1: 1 = misaligned access returns `resp_err` with no memory access; 0 = low address bits beyond natural alignment are ignored.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, request accepted when `req_valid & req_ready` at a rising edge.
- `req_load` in 1: 1 = load, 0 = store.
- `req_funct3` in 3: RV32I funct3 (loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, low bits used for SB/SH.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; misaligned or illegal funct3.
- `Mem_read` out 1: to `data_memory`.
- `Mem_write` out 1: to `data_memory`.
- `mem_addr` out 32: word-aligned byte address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: full word to write.
- `Read_data` in 32: from `data_memory`; valid the cycle after `Mem_read` is asserted with `mem_addr` held.

## Operation
- Request fields are latched on acceptance. Inputs are ignored while `req_ready` = 0.
- FSM states are IDLE, LD_RD, LD_WAIT, RMW_RD, RMW_WAIT, ST_WR, RESP.
- IDLE: `req_ready` = 1. On acceptance:
  - illegal funct3 or misaligned (CHECK_ALIGN=1) → RESP with err;
  - load → LD_RD;
  - SW → ST_WR;
  - SB/SH → RMW_RD.
- Misalignment rule: LH/LHU/SH with `addr[0]` = 1; LW/SW with `addr[1:0]` ≠ 0.
- LD_RD → LD_WAIT: `Mem_read` = 1 in both states. At the end of LD_WAIT the selected byte/half of `Read_data` is captured and extended:
  - byte lane = `addr[1:0]`, half lane = `addr[1]`, little-endian;
  - LB/LH sign-extend, LBU/LHU zero-extend.
- RMW_RD → RMW_WAIT: `Mem_read` = 1. At the end of RMW_WAIT the `Read_data` word is captured with the byte/half lane replaced by `req_wdata[7:0]`/`[15:0]`, then → ST_WR.
- ST_WR: `Mem_write` = 1 for exactly one cycle with `mem_wdata` = merged word (or `req_wdata` for SW), then → RESP.
- RESP: `resp_valid` = 1 for one cycle, then → IDLE. No response backpressure.
- `mem_addr` is held constant from the first access cycle through ST_WR.
- `Mem_read` and `Mem_write` are never both 1.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0, `Mem_read` = 0, `Mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Latency from the acceptance edge to the `resp_valid` cycle:
  - error: 1 cycle;
  - SW: 2 cycles;
  - load: 3 cycles;
  - SB/SH: 4 cycles.
- Back-to-back: a new request can be accepted in the cycle after RESP (IDLE). Throughput is at most 1 request per (latency+1) cycles.
- Reset mid-operation:
  - `Mem_read` and `Mem_write` are combinationally forced 0 in any cycle where `reset` = 0, so an in-flight RMW or SW never writes;
  - the next state is IDLE and any pending response is dropped.
- `req_valid` held high through RESP does not re-trigger. A new acceptance occurs only in IDLE.

## Test plan
- Preload word 0x10 = 0x876543F0, then issue:
  - LB 0x10 → `resp_rdata` = 0xFFFFFFF0, `resp_valid` 3 cycles after acceptance, `Mem_read` high exactly 2 cycles;
  - LBU 0x13 → 0x00000087;
  - LH 0x12 → 0xFFFF8765;
  - LHU 0x12 → 0x00008765.
- SB 0xAB to 0x11 (word 0x876543F0) → reads then one `Mem_write` cycle with `mem_addr` = 0x10, `mem_wdata` = 0x8765ABF0; `resp_valid` 4 cycles after acceptance.
- SW 0x0000000C to 0x08 → single `Mem_write` cycle with `mem_addr` = 0x08, `mem_wdata` = 0x0000000C, no `Mem_read`; `resp_valid` at +2; a subsequent LW 0x08 returns 0x0000000C.
- LW 0x06 and SH 0x03 (CHECK_ALIGN=1) → `resp_err` = 1, `resp_rdata` = 0 at +1, `Mem_read`/`Mem_write` never asserted. With funct3 = 011 → `resp_err` = 1.
- SH 0xBEEF to 0x12 with `reset` driven low during RMW_WAIT → `Mem_write` never asserts, memory word unchanged, no `resp_valid`, `req_ready` = 1 the cycle after reset releases.
- `req_valid` held high continuously with alternating LW/SW → each request accepted only in IDLE, exactly one `resp_valid` per accepted request, `Mem_read` & `Mem_write` never both 1.
